// File: rtl/msg_crypt_pkg.sv
// Shared definitions for the LFSR message cipher: tap table, special
// characters, default memory map and the decryptor state encoding.
package msg_crypt_pkg;

    // Default memory map and block geometry
    localparam int MSG_BASE_DEF = 64;
    localparam int OUT_BASE_DEF = 0;
    localparam int MSG_LEN_DEF  = 64;
    localparam int MIN_PRE_DEF  = 10;

    // Candidate feedback tap patterns, index 0..8
    localparam int NUM_TAPS = 9;
    localparam logic [6:0] LFSR_TAPS [0:NUM_TAPS-1] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    localparam logic [7:0] SPACE     = 8'h20;
    localparam logic [6:0] SPACE7    = 7'h20;
    localparam logic [7:0] PERR_CHAR = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_SEARCH = 3'd2,
        ST_DEC_RD = 3'd3,
        ST_DEC_WR = 3'd4,
        ST_PAD    = 3'd5,
        ST_DONE   = 3'd6,
        ST_FAIL   = 3'd7
    } state_t;

    // One LFSR step: shift left, feedback is the parity of the tapped bits
    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] tap);
        return {s[5:0], ^(s & tap)};
    endfunction

endpackage

// File: rtl/msg_decrypt_engine_if.sv
// Control and data-memory bus of the message decryptor.
//
// Start/Ack convention: the controller holds Start=1 while the engine is
// idle; a 1->0 transition launches one run. The engine raises Ack (and Fail
// when no tap pattern matched) at the end of the run and holds it until
// Start returns to 1. Start changes during a run are ignored. Memory is a
// single shared port: Mem_Addr selects the location, Mem_WrEn writes
// Mem_WrData in that cycle, Mem_RdData returns the addressed byte one cycle
// later.
interface msg_decrypt_engine_if;
    import msg_crypt_pkg::*;

    logic       Start;
    logic       Ack;
    logic       Fail;
    logic [7:0] Mem_Addr;
    logic [7:0] Mem_RdData;
    logic       Mem_WrEn;
    logic [7:0] Mem_WrData;
    logic [3:0] Tap_Sel;
    logic [6:0] Lfsr_Init;
    logic [6:0] Parity_Errs;
    state_t     Dbg_State;

    // Engine side
    modport master (
        input  Start, Mem_RdData,
        output Ack, Fail, Mem_Addr, Mem_WrEn, Mem_WrData,
               Tap_Sel, Lfsr_Init, Parity_Errs, Dbg_State
    );

    // Controller / memory side
    modport slave (
        output Start, Mem_RdData,
        input  Ack, Fail, Mem_Addr, Mem_WrEn, Mem_WrData,
               Tap_Sel, Lfsr_Init, Parity_Errs, Dbg_State
    );

endinterface

// File: rtl/msg_decrypt_engine_lfsr7.sv
// 7-bit Fibonacci-style LFSR with load and step controls. Load wins over
// step. The combinational next value is exported so the caller can compare
// against it before committing the step.
module lfsr7
    import msg_crypt_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    input  logic [6:0] seed,
    input  logic [6:0] tap,
    output logic [6:0] value,
    output logic [6:0] value_next
);

    assign value_next = lfsr_next(value, tap);

    // LFSR state: reload from seed or advance one step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= 7'd0;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/msg_decrypt_engine.sv
// Hardware decryptor for the LFSR-XOR/parity cipher. Reads the encrypted
// block, recovers seed and tap pattern from the known space preamble,
// decrypts with parity checking, strips leading spaces and writes the
// plaintext back space-padded.
module msg_decrypt_engine
    import msg_crypt_pkg::*;
#(
    parameter int MSG_BASE = MSG_BASE_DEF,
    parameter int OUT_BASE = OUT_BASE_DEF,
    parameter int MSG_LEN  = MSG_LEN_DEF,
    parameter int MIN_PRE  = MIN_PRE_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    msg_decrypt_engine_if.master bus
);

    localparam logic [7:0] MSG_BASE_A = 8'(MSG_BASE);
    localparam logic [7:0] OUT_BASE_A = 8'(OUT_BASE);
    localparam logic [6:0] LEN_END    = 7'(MSG_LEN);
    localparam logic [6:0] LEN_LAST   = 7'(MSG_LEN - 1);
    localparam logic [3:0] PRE_END    = 4'(MIN_PRE);
    localparam logic [3:0] PRE_LAST   = 4'(MIN_PRE - 1);
    localparam logic [3:0] TAP_LAST   = 4'(NUM_TAPS - 1);

    state_t     state;
    state_t     state_next;
    logic       start_q;

    // Header capture and tap search
    logic [3:0] hdr_cnt;
    logic [6:0] pre_buf [MIN_PRE];
    logic [3:0] cand_k;
    logic [3:0] cand_i;

    // Decrypt / pad pointers
    logic [6:0] byte_n;
    logic [6:0] out_ptr;
    logic       strip_on;

    // Result registers
    logic [3:0] tap_sel_q;
    logic [6:0] lfsr_init_q;
    logic [6:0] perr_cnt;

    // LFSR control and datapath decode
    logic       lfsr_load;
    logic       lfsr_step;
    logic [6:0] lfsr_seed;
    logic [6:0] lfsr_tap;
    logic [6:0] lfsr_val;
    logic [6:0] lfsr_nxt;
    logic [6:0] hdr_seed;
    logic       launch;
    logic       cand_ok;
    logic       cand_last;
    logic       par_err;
    logic [7:0] dec_char;
    logic       dec_skip;

    // Single LFSR shared by the tap search and the decrypt pass
    lfsr7 u_lfsr (
        .clk        (Clk),
        .rst_n      (Reset),
        .load       (lfsr_load),
        .step       (lfsr_step),
        .seed       (lfsr_seed),
        .tap        (lfsr_tap),
        .value      (lfsr_val),
        .value_next (lfsr_nxt)
    );

    // Datapath decode: launch edge, candidate compare, byte decryption
    always_comb begin
        hdr_seed  = pre_buf[0] ^ SPACE7;
        launch    = start_q && !bus.Start;
        lfsr_tap  = (state == ST_SEARCH) ? LFSR_TAPS[cand_k] : LFSR_TAPS[tap_sel_q];
        cand_ok   = (pre_buf[cand_i] ^ lfsr_nxt) == SPACE7;
        cand_last = (cand_i == PRE_LAST);
        par_err   = bus.Mem_RdData[7] != ^bus.Mem_RdData[6:0];
        dec_char  = par_err ? PERR_CHAR : {1'b0, bus.Mem_RdData[6:0] ^ lfsr_val};
        dec_skip  = strip_on && (dec_char == SPACE);
    end

    // FSM state register; reset aborts any run immediately
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (launch) state_next = ST_HDR;
            ST_HDR:    if (hdr_cnt == PRE_END) state_next = ST_SEARCH;
            ST_SEARCH: begin
                if (cand_ok && cand_last) begin
                    state_next = ST_DEC_RD;
                end else if (!cand_ok && (cand_k == TAP_LAST)) begin
                    state_next = ST_FAIL;
                end
            end
            ST_DEC_RD: state_next = ST_DEC_WR;
            ST_DEC_WR: state_next = (byte_n == LEN_LAST) ? ST_PAD : ST_DEC_RD;
            ST_PAD:    if (out_ptr >= LEN_LAST) state_next = ST_DONE;
            ST_DONE,
            ST_FAIL:   if (bus.Start) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: memory port mux, handshake flags, LFSR control
    always_comb begin
        bus.Mem_Addr   = 8'd0;
        bus.Mem_WrEn   = 1'b0;
        bus.Mem_WrData = 8'd0;
        bus.Ack        = 1'b0;
        bus.Fail       = 1'b0;
        lfsr_load      = 1'b0;
        lfsr_step      = 1'b0;
        lfsr_seed      = lfsr_init_q;
        case (state)
            ST_HDR: begin
                bus.Mem_Addr = MSG_BASE_A + {4'd0, hdr_cnt};
                if (hdr_cnt == PRE_END) begin
                    // Seed is not yet registered in Lfsr_Init on this cycle
                    lfsr_load = 1'b1;
                    lfsr_seed = hdr_seed;
                end
            end
            ST_SEARCH: begin
                // Advance while the candidate keeps matching; otherwise
                // restart from the seed for the next candidate or for DEC
                if (cand_ok && !cand_last) begin
                    lfsr_step = 1'b1;
                end else begin
                    lfsr_load = 1'b1;
                end
            end
            ST_DEC_RD: begin
                bus.Mem_Addr = MSG_BASE_A + {1'b0, byte_n};
            end
            ST_DEC_WR: begin
                bus.Mem_Addr   = OUT_BASE_A + {1'b0, out_ptr};
                bus.Mem_WrEn   = !dec_skip;
                bus.Mem_WrData = dec_char;
                lfsr_step      = 1'b1;
            end
            ST_PAD: begin
                bus.Mem_Addr   = OUT_BASE_A + {1'b0, out_ptr};
                bus.Mem_WrEn   = (out_ptr != LEN_END);
                bus.Mem_WrData = SPACE;
            end
            ST_DONE: begin
                bus.Ack = 1'b1;
            end
            ST_FAIL: begin
                bus.Ack  = 1'b1;
                bus.Fail = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters, pointers and result registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            start_q     <= 1'b0;
            hdr_cnt     <= 4'd0;
            cand_k      <= 4'd0;
            cand_i      <= 4'd1;
            byte_n      <= 7'd0;
            out_ptr     <= 7'd0;
            strip_on    <= 1'b1;
            tap_sel_q   <= 4'd0;
            lfsr_init_q <= 7'd0;
            perr_cnt    <= 7'd0;
        end else begin
            start_q <= bus.Start;
            case (state)
                ST_IDLE: begin
                    hdr_cnt  <= 4'd0;
                    cand_k   <= 4'd0;
                    cand_i   <= 4'd1;
                    byte_n   <= 7'd0;
                    out_ptr  <= 7'd0;
                    strip_on <= 1'b1;
                    perr_cnt <= 7'd0;
                end
                ST_HDR: begin
                    hdr_cnt <= hdr_cnt + 4'd1;
                    if (hdr_cnt == PRE_END) begin
                        lfsr_init_q <= hdr_seed;
                    end
                end
                ST_SEARCH: begin
                    if (cand_ok) begin
                        if (cand_last) begin
                            tap_sel_q <= cand_k;
                        end else begin
                            cand_i <= cand_i + 4'd1;
                        end
                    end else begin
                        cand_k <= cand_k + 4'd1;
                        cand_i <= 4'd1;
                    end
                end
                ST_DEC_WR: begin
                    byte_n <= byte_n + 7'd1;
                    if (par_err && (perr_cnt != 7'h7F)) begin
                        perr_cnt <= perr_cnt + 7'd1;
                    end
                    if (!dec_skip) begin
                        out_ptr  <= out_ptr + 7'd1;
                        strip_on <= 1'b0;
                    end
                end
                ST_PAD: begin
                    if (out_ptr != LEN_END) begin
                        out_ptr <= out_ptr + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Preamble buffer: byte c-1 arrives while hdr_cnt == c (registered read)
    always_ff @(posedge Clk) begin
        if ((state == ST_HDR) && (hdr_cnt != 4'd0)) begin
            pre_buf[hdr_cnt - 4'd1] <= bus.Mem_RdData[6:0];
        end
    end

    assign bus.Tap_Sel     = tap_sel_q;
    assign bus.Lfsr_Init   = lfsr_init_q;
    assign bus.Parity_Errs = perr_cnt;
    assign bus.Dbg_State   = state;

endmodule

// File: tb/tb_msg_decrypt_engine.sv
// Bench for msg_decrypt_engine: encrypts directed messages with a local
// cipher model, runs the engine against a registered-read memory model and
// compares the plaintext image and result outputs with hand-derived values.
module tb_msg_decrypt_engine;
    import msg_crypt_pkg::*;

    localparam int TB_MSG_BASE = 64;
    localparam int TB_OUT_BASE = 0;
    localparam int ACK_BUDGET  = 1000;
    localparam int MAX_LATENCY = 286;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msg_decrypt_engine_if bus();

    msg_decrypt_engine dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    // ---------------- memory model ----------------
    logic [7:0]  mem [256];
    logic        ld_en   = 1'b0;
    logic [7:0]  ld_addr = 8'd0;
    logic [7:0]  ld_data = 8'd0;
    int unsigned wr_total = 0;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (bus.Mem_WrEn) begin
            mem[bus.Mem_Addr] <= bus.Mem_WrData;
        end
        bus.Mem_RdData <= mem[bus.Mem_Addr];
        if (bus.Mem_WrEn) wr_total <= wr_total + 1;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] enc_img [64];
    logic [7:0] exp_img [64];
    string msg = "Mr. Watson, come here. I want to see you.";

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic check_image(input string name);
        int bad;
        logic [7:0] fa;
        bad = 0;
        fa = 8'd0;
        for (int a = 0; a < 64; a++) begin
            if (mem[8'(TB_OUT_BASE + a)] !== exp_img[a]) begin
                if (bad == 0) fa = 8'(a);
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s addr=%0d got=%02h exp=%02h bad_bytes=%0d",
                     name, fa, mem[8'(TB_OUT_BASE) + fa], exp_img[fa[5:0]], bad);
        end
    endtask

    // ---------------- cipher model / driver tasks ----------------
    // Plaintext = pre spaces + txt, space padded; c = p ^ s_n, bit7 = parity
    task automatic build_case(input bit blank, input logic [6:0] tap, input logic [6:0] seed,
                              input int pre, input int flip, input int perr_out, input bit zero_img);
        logic [6:0] s;
        logic [7:0] p;
        logic [6:0] c;
        int tl;
        tl = blank ? 0 : msg.len();
        s = seed;
        for (int n = 0; n < 64; n++) begin
            if (n >= pre && (n - pre) < tl) p = msg[n - pre];
            else p = 8'h20;
            c = p[6:0] ^ s;
            enc_img[n] = zero_img ? 8'h00 : {^c, c};
            if (n == flip) enc_img[n][7] = ~enc_img[n][7];
            s = {s[5:0], ^(s & tap)};
            if (zero_img) exp_img[n] = 8'hEE;
            else if (n < tl) exp_img[n] = msg[n];
            else exp_img[n] = 8'h20;
        end
        if (perr_out >= 0) exp_img[perr_out] = 8'h80;
    endtask

    // Input block at MSG_BASE, output region pre-filled with a marker
    task automatic load_images();
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 8'(TB_MSG_BASE + a); ld_data = enc_img[a];
        end
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 8'(TB_OUT_BASE + a); ld_data = 8'hEE;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    typedef struct {
        bit         blank;
        logic [6:0] tap;
        logic [6:0] seed;
        int         pre;
        int         flip;
        int         perr_out;
        bit         zero_img;
        bit         raise_mid;
        bit         exp_fail;
        logic [3:0] exp_tap;
        logic [6:0] exp_init;
        logic [6:0] exp_perrs;
        int         exp_writes;
    } vec_t;

    vec_t vecs [5];

    // Launch, wait for Ack, compare results, then release with Start=1
    task automatic run_and_check(input string tag, input vec_t v);
        int cyc;
        int unsigned wr0;
        wr0 = wr_total;
        @(negedge clk);
        bus.Start = 1'b0;
        cyc = 0;
        while (bus.Ack !== 1'b1 && cyc < ACK_BUDGET) begin
            @(negedge clk);
            cyc++;
            if (v.raise_mid && cyc == 40) bus.Start = 1'b1;
        end
        check({tag, "_ack"}, int'(bus.Ack), 1);
        check({tag, "_latency_ok"}, int'(cyc <= MAX_LATENCY), 1);
        check({tag, "_fail"}, int'(bus.Fail), int'(v.exp_fail));
        if (!v.exp_fail) check({tag, "_tap_sel"}, int'(bus.Tap_Sel), int'(v.exp_tap));
        check({tag, "_lfsr_init"}, int'(bus.Lfsr_Init), int'(v.exp_init));
        check({tag, "_parity_errs"}, int'(bus.Parity_Errs), int'(v.exp_perrs));
        check({tag, "_writes"}, int'(wr_total - wr0), v.exp_writes);
        check_image({tag, "_dm_image"});
        bus.Start = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_ack_release"}, int'(bus.Ack), 0);
        check({tag, "_fail_release"}, int'(bus.Fail), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned wr_rst;
        bus.Start = 1'b1;

        vecs[0] = '{blank:0, tap:7'h60, seed:7'h01, pre:10, flip:-1, perr_out:-1, zero_img:0,
                    raise_mid:0, exp_fail:0, exp_tap:4'd0, exp_init:7'h01, exp_perrs:7'd0, exp_writes:64};
        vecs[1] = '{blank:0, tap:7'h7B, seed:7'h55, pre:15, flip:-1, perr_out:-1, zero_img:0,
                    raise_mid:1, exp_fail:0, exp_tap:4'd8, exp_init:7'h55, exp_perrs:7'd0, exp_writes:64};
        vecs[2] = '{blank:0, tap:7'h60, seed:7'h01, pre:10, flip:16, perr_out:6, zero_img:0,
                    raise_mid:0, exp_fail:0, exp_tap:4'd0, exp_init:7'h01, exp_perrs:7'd1, exp_writes:64};
        vecs[3] = '{blank:0, tap:7'h60, seed:7'h01, pre:10, flip:-1, perr_out:-1, zero_img:1,
                    raise_mid:0, exp_fail:1, exp_tap:4'd0, exp_init:7'h20, exp_perrs:7'd0, exp_writes:0};
        vecs[4] = '{blank:1, tap:7'h48, seed:7'h7F, pre:10, flip:-1, perr_out:-1, zero_img:0,
                    raise_mid:0, exp_fail:0, exp_tap:4'd1, exp_init:7'h7F, exp_perrs:7'd0, exp_writes:64};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", int'(bus.Ack), 0);
        check("rst_fail", int'(bus.Fail), 0);
        check("rst_wren", int'(bus.Mem_WrEn), 0);
        check("rst_lfsr_init", int'(bus.Lfsr_Init), 0);
        check("rst_state", int'(bus.Dbg_State), int'(ST_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven cases
        for (int i = 0; i < 5; i++) begin
            build_case(vecs[i].blank, vecs[i].tap, vecs[i].seed, vecs[i].pre,
                       vecs[i].flip, vecs[i].perr_out, vecs[i].zero_img);
            load_images();
            run_and_check($sformatf("case%0d", i + 1), vecs[i]);
        end

        // Reset in the middle of the decrypt pass, then a clean re-run
        build_case(vecs[0].blank, vecs[0].tap, vecs[0].seed, vecs[0].pre,
                   vecs[0].flip, vecs[0].perr_out, vecs[0].zero_img);
        load_images();
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (120) @(negedge clk);
        check("abort_mid_dec", int'(bus.Dbg_State == ST_DEC_RD || bus.Dbg_State == ST_DEC_WR), 1);
        rst_n = 1'b0;
        #1;
        check("abort_wren", int'(bus.Mem_WrEn), 0);
        check("abort_ack", int'(bus.Ack), 0);
        check("abort_lfsr_init", int'(bus.Lfsr_Init), 0);
        check("abort_tap_sel", int'(bus.Tap_Sel), 0);
        check("abort_parity_errs", int'(bus.Parity_Errs), 0);
        check("abort_addr", int'(bus.Mem_Addr), 0);
        check("abort_state", int'(bus.Dbg_State), int'(ST_IDLE));
        wr_rst = wr_total;
        bus.Start = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_writes", int'(wr_total - wr_rst), 0);
        rst_n = 1'b1;
        load_images();
        run_and_check("rerun", vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound in case a wait is never satisfied
    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
